// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : vga_timing_ctrl
// Description : VGA scan timing in the clk_in domain, driven by a pixel-enable
//               prescaler. Starts and stops only on frame boundaries.
// Revision    : 1.0 - initial release
// =============================================================================
module vga_timing_ctrl #(
    parameter int   PIX_DIV   = 4,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CNT_W     = 10
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    output logic             running,
    output logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int c_PS_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0]  c_H_LAST  = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  c_V_LAST  = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  c_H_VIS   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0]  c_V_VIS   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0]  c_HS_BEG  = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0]  c_HS_END  = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0]  c_VS_BEG  = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0]  c_VS_END  = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_PS_W-1:0]  r_presc;
    logic [c_PS_W-1:0]  w_presc_nxt;
    logic [CNT_W-1:0]   r_h;
    logic [CNT_W-1:0]   r_v;
    logic [CNT_W-1:0]   w_h_nxt;
    logic [CNT_W-1:0]   w_v_nxt;
    logic               w_tick;
    logic               w_h_wrap;
    logic               w_f_wrap;
    logic               w_active_nxt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    always_comb begin
        w_tick      = (r_state != S_IDLE) && (r_presc == c_PS_LAST);
        w_h_wrap    = w_tick && (r_h == c_H_LAST);
        w_f_wrap    = w_h_wrap && (r_v == c_V_LAST);
        w_state_nxt = r_state;
        w_presc_nxt = '0;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;

        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_RUN;
            S_RUN:   if (!en) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (en)            w_state_nxt = S_RUN;
                else if (w_f_wrap) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (r_state != S_IDLE && !w_tick)
            w_presc_nxt = r_presc + 1'b1;

        // The stopping wrap lands on (0,0), so IDLE always holds zeroed counters
        if (w_tick) begin
            if (w_h_wrap) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                w_h_nxt = r_h + 1'b1;
            end
        end

        w_active_nxt = (w_state_nxt != S_IDLE);
    end

    // Outputs decode the next counter values so they align with the counters
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            running     <= 1'b0;
            pix_tick    <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            running     <= w_active_nxt;
            pix_tick    <= w_tick;
            hsync       <= (w_active_nxt && w_h_nxt >= c_HS_BEG && w_h_nxt < c_HS_END)
                           ? HS_POL : ~HS_POL;
            vsync       <= (w_active_nxt && w_v_nxt >= c_VS_BEG && w_v_nxt < c_VS_END)
                           ? VS_POL : ~VS_POL;
            video_on    <= w_active_nxt && (w_h_nxt < c_H_VIS) && (w_v_nxt < c_V_VIS);
            line_start  <= w_active_nxt && w_h_wrap;
            frame_start <= w_active_nxt && ((r_state == S_IDLE) || w_f_wrap);
        end
    end

    assign pix_x = r_h;
    assign pix_y = r_v;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Randomized en/rst stimulus against a pixel-position reference
//               model, using small timing parameters.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_vga_timing_ctrl;

    localparam int PD    = 2;
    localparam int HV    = 8;
    localparam int HFP   = 1;
    localparam int HSW   = 2;
    localparam int HBP   = 1;
    localparam int VV    = 4;
    localparam int VFP   = 1;
    localparam int VSW   = 1;
    localparam int VBP   = 1;
    localparam int CW    = 4;
    localparam int HT    = HV + HFP + HSW + HBP;
    localparam int VT    = VV + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int LIMIT = 4 * FRAME * PD;

    logic          clk_in = 1'b0;
    logic          rst    = 1'b1;
    logic          en     = 1'b0;
    logic          running, pix_tick, hsync, vsync, video_on, line_start, frame_start;
    logic [CW-1:0] pix_x, pix_y;

    always #5 clk_in = ~clk_in;

    vga_timing_ctrl #(
        .PIX_DIV(PD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
    ) u_dut (
        .clk_in(clk_in), .rst(rst), .en(en),
        .running(running), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a running flag, a drain request and a linear pixel index
    int m_run = 0, m_drain = 0, m_phase = 0, m_pos = 0;
    int m_tick = 0, m_ls = 0, m_fs = 0;
    bit chk_on = 1'b0;

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_run = 0; m_drain = 0; m_phase = 0; m_pos = 0;
            m_tick = 0; m_ls = 0; m_fs = 0;
        end else begin
            m_tick = 0; m_ls = 0; m_fs = 0;
            if (m_run == 0) begin
                if (en) begin
                    m_run = 1; m_drain = 0; m_phase = 0; m_pos = 0; m_fs = 1;
                end
            end else begin
                if (m_phase == PD - 1) begin
                    m_tick  = 1;
                    m_phase = 0;
                    m_pos   = (m_pos + 1) % FRAME;
                    if (m_pos == 0 && m_drain == 1 && !en) begin
                        m_run = 0;
                    end else begin
                        m_ls = (m_pos % HT == 0) ? 1 : 0;
                        m_fs = (m_pos == 0) ? 1 : 0;
                    end
                end else begin
                    m_phase++;
                end
                if (m_run == 1) m_drain = en ? 0 : 1;
            end
        end
    end

    always @(negedge clk_in) begin
        int x, y;
        if (chk_on) begin
            x = m_pos % HT;
            y = m_pos / HT;
            check("running", running, m_run);
            check("pix_tick", pix_tick, m_tick);
            check("pix_x", pix_x, x);
            check("pix_y", pix_y, y);
            check("hsync", hsync, (m_run == 1 && x >= HV + HFP && x < HV + HFP + HSW) ? 0 : 1);
            check("vsync", vsync, (m_run == 1 && y >= VV + VFP && y < VV + VFP + VSW) ? 0 : 1);
            check("video_on", video_on, (m_run == 1 && x < HV && y < VV) ? 1 : 0);
            check("line_start", line_start, m_ls);
            check("frame_start", frame_start, m_fs);
        end
    end

    task automatic wait_pos(input int p);
        int k;
        k = 0;
        while (!(m_run == 1 && m_pos == p && m_phase == 0) && k < LIMIT) begin
            @(negedge clk_in);
            k++;
        end
        check("wait_pos_timeout", (k < LIMIT) ? 1 : 0, 1);
        #2;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_run != 0 && k < LIMIT) begin
            @(negedge clk_in);
            k++;
        end
        check("wait_idle_timeout", (k < LIMIT) ? 1 : 0, 1);
        @(negedge clk_in);
        check("idle_running", running, 0);
        check("idle_pix_x", pix_x, 0);
        check("idle_pix_y", pix_y, 0);
        #2;
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        chk_on = 1'b1;
        @(negedge clk_in);
        #2 rst = 1'b0;

        // Continuous run across three frames
        en = 1'b1;
        repeat (3 * FRAME * PD + 10) @(negedge clk_in);
        #2;

        // Drain mid-frame, resume within the same frame, then drain to idle
        wait_pos(2 * HT + 3);
        en = 1'b0;
        wait_pos(4 * HT + 5);
        en = 1'b1;
        wait_pos(HT + 1);
        en = 1'b0;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            en = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(1, 400)) @(negedge clk_in);
            #2;
        end

        // Asynchronous reset mid-frame
        en = 1'b1;
        repeat (37) @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        check("rst_running", running, 0);
        check("rst_pix_tick", pix_tick, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_video_on", video_on, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_frame_start", frame_start, 0);
        @(negedge clk_in);
        #2 rst = 1'b0;
        repeat (50) @(negedge clk_in);
        #2 en = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
